// File: rtl/state_xor_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module  : state_xor_bank_pkg
// Brief   : Shared constants and the channel-index width helper for the
//           state_xor_bank block.
// Revision: 1.0 - initial release
// ============================================================================
package state_xor_bank_pkg;

  // Default MSB of a channel state word (4-bit states).
  localparam int STMSB_DEF = 3;

  // Default reset state of every channel.
  localparam logic [STMSB_DEF:0] ST0_DEF = '0;

  // Channel-index width: at least one bit, even for a single channel.
  function automatic int cw_of(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/state_xor_bank_if.sv
`default_nettype none
// ============================================================================
// Module  : state_xor_bank_if
// Brief   : Change-event record stream (valid/ready handshake plus payload).
// Revision: 1.0 - initial release
// ============================================================================
interface state_xor_bank_if #(
  parameter int CW = 2,
  parameter int W  = 4
);

  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_ch;
  logic [W-1:0]  evt_old;
  logic [W-1:0]  evt_new;

  // Record producer side.
  modport master (
    output evt_valid,
    output evt_ch,
    output evt_old,
    output evt_new,
    input  evt_ready
  );

  // Record consumer side.
  modport slave (
    input  evt_valid,
    input  evt_ch,
    input  evt_old,
    input  evt_new,
    output evt_ready
  );

endinterface
`default_nettype wire

// File: rtl/state_xor_bank_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb
// Brief   : Round-robin request picker. Search begins one past ptr and
//           wraps, so the most recently granted channel is checked last.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb
  import state_xor_bank_pkg::*;
#(
  parameter int CH = 4
) (
  input  logic [CH-1:0]         req,
  input  logic [cw_of(CH)-1:0]  ptr,
  output logic [CH-1:0]         gnt,
  output logic [cw_of(CH)-1:0]  idx
);

  localparam int CW = cw_of(CH);

  logic found;
  int   j;

  // Walk the channels starting after ptr; first requester wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= CH; k++) begin
      j = (int'(ptr) + k) % CH;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = CW'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/state_xor_bank.sv
`default_nettype none
// ============================================================================
// Module  : state_xor_bank
// Brief   : Bank of CH state registers. Every qualifying state change is
//           recorded per channel (coalescing with an overflow flag when a
//           record is still pending) and drained one record at a time
//           through a round-robin arbitrated valid/ready slot.
// Revision: 1.0 - initial release
// ============================================================================
module state_xor_bank
  import state_xor_bank_pkg::*;
#(
  parameter int               CH    = 4,
  parameter int               STMSB = STMSB_DEF,
  parameter logic [STMSB:0]   ST0   = ST0_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   setn,
  input  logic [CH-1:0]          en,
  input  logic [CH*(STMSB+1)-1:0] nst,
  output logic [CH*(STMSB+1)-1:0] cst,
  output logic [CH-1:0]          xst,
  state_xor_bank_if.master       evt,
  output logic [CH-1:0]          ovf,
  input  logic                   ovf_clr
);

  localparam int W  = STMSB + 1;
  localparam int CW = cw_of(CH);

  logic [CH*W-1:0] cst_q,       cst_d;
  logic [CH-1:0]   pending_q,   pending_d;
  logic [CH-1:0]   ovf_q,       ovf_d;
  logic [CW-1:0]   ptr_q,       ptr_d;
  logic [W-1:0]    rec_old_q [CH];
  logic [W-1:0]    rec_old_d [CH];
  logic [W-1:0]    rec_new_q [CH];
  logic [W-1:0]    rec_new_d [CH];
  logic            evt_valid_q, evt_valid_d;
  logic [CW-1:0]   evt_ch_q,    evt_ch_d;
  logic [W-1:0]    evt_old_q,   evt_old_d;
  logic [W-1:0]    evt_new_q,   evt_new_d;

  logic [CH-1:0]   gnt;
  logic [CW-1:0]   gnt_idx;
  logic [W-1:0]    sel_old;
  logic [W-1:0]    sel_new;
  logic            slot_free;

  rr_arb #(
    .CH (CH)
  ) u_rr_arb (
    .req (pending_q),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // Per-channel "would change" flag, purely from the current inputs/state.
  always_comb begin
    xst = '0;
    for (int i = 0; i < CH; i++) begin
      xst[i] = (nst[i*W +: W] != cst_q[i*W +: W]);
    end
  end

  // Select the granted channel's pending record for the output slot.
  always_comb begin
    sel_old = '0;
    sel_new = '0;
    for (int i = 0; i < CH; i++) begin
      if (gnt[i]) begin
        sel_old = rec_old_q[i];
        sel_new = rec_new_q[i];
      end
    end
  end

  // Next-state: state update, record capture/coalescing, slot load, preset.
  always_comb begin
    cst_d       = cst_q;
    pending_d   = pending_q;
    ovf_d       = ovf_q & ~{CH{ovf_clr}};
    ptr_d       = ptr_q;
    rec_old_d   = rec_old_q;
    rec_new_d   = rec_new_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_old_d   = evt_old_q;
    evt_new_d   = evt_new_q;
    slot_free   = !evt_valid_q || evt.evt_ready;

    if (!setn) begin
      // Preset loads every channel silently and drops all queued records.
      cst_d       = nst;
      pending_d   = '0;
      evt_valid_d = 1'b0;
    end else begin
      if (slot_free) begin
        if (|pending_q) begin
          evt_valid_d = 1'b1;
          evt_ch_d    = gnt_idx;
          evt_old_d   = sel_old;
          evt_new_d   = sel_new;
          ptr_d       = gnt_idx;
          pending_d   = pending_q & ~gnt;
        end else begin
          evt_valid_d = 1'b0;
        end
      end

      for (int i = 0; i < CH; i++) begin
        if (en[i] && xst[i]) begin
          cst_d[i*W +: W] = nst[i*W +: W];
          // A record leaving through the slot this edge frees the channel,
          // so the change starts a fresh record rather than coalescing.
          if (pending_q[i] && !(slot_free && gnt[i])) begin
            rec_new_d[i] = nst[i*W +: W];
            ovf_d[i]     = 1'b1;
          end else begin
            pending_d[i] = 1'b1;
            rec_old_d[i] = cst_q[i*W +: W];
            rec_new_d[i] = nst[i*W +: W];
          end
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cst_q       <= {CH{ST0}};
      pending_q   <= '0;
      ovf_q       <= '0;
      ptr_q       <= CW'(CH - 1);
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_old_q   <= '0;
      evt_new_q   <= '0;
      for (int i = 0; i < CH; i++) begin
        rec_old_q[i] <= '0;
        rec_new_q[i] <= '0;
      end
    end else begin
      cst_q       <= cst_d;
      pending_q   <= pending_d;
      ovf_q       <= ovf_d;
      ptr_q       <= ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_old_q   <= evt_old_d;
      evt_new_q   <= evt_new_d;
      rec_old_q   <= rec_old_d;
      rec_new_q   <= rec_new_d;
    end
  end

  assign cst           = cst_q;
  assign ovf           = ovf_q;
  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_ch    = evt_ch_q;
  assign evt.evt_old   = evt_old_q;
  assign evt.evt_new   = evt_new_q;

endmodule
`default_nettype wire

// File: tb/tb_state_xor_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_state_xor_bank
// Brief   : Directed-vector bench for state_xor_bank (CH=4, 4-bit states).
// Revision: 1.0 - initial release
// ============================================================================
module tb_state_xor_bank;

  localparam int CH = 4;
  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk;
  logic          rstn;
  logic          setn;
  logic [CH-1:0] en;
  logic [CH*W-1:0] nst;
  logic [CH*W-1:0] cst;
  logic [CH-1:0] xst;
  logic [CH-1:0] ovf;
  logic          ovf_clr;

  int n_vec;
  int n_err;

  state_xor_bank_if #(.CW(CW), .W(W)) evt_if ();

  state_xor_bank #(
    .CH    (CH),
    .STMSB (W - 1),
    .ST0   (4'h0)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .setn    (setn),
    .en      (en),
    .nst     (nst),
    .cst     (cst),
    .xst     (xst),
    .evt     (evt_if.master),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic check_evt(input string tag, input logic v, input logic [CW-1:0] ch,
                           input logic [W-1:0] o, input logic [W-1:0] n);
    check_eq({tag, ".valid"}, 32'(evt_if.evt_valid), 32'(v));
    if (v) begin
      check_eq({tag, ".ch"},  32'(evt_if.evt_ch),  32'(ch));
      check_eq({tag, ".old"}, 32'(evt_if.evt_old), 32'(o));
      check_eq({tag, ".new"}, 32'(evt_if.evt_new), 32'(n));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn = 1'b0; setn = 1'b1; en = '0; nst = '0; ovf_clr = 1'b0;
    evt_if.evt_ready = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst.cst", 32'(cst), 32'h0);
    check_evt("rst.evt", 1'b0, '0, '0, '0);
    check_eq("rst.evt_ch", 32'(evt_if.evt_ch), 32'h0);
    check_eq("rst.ovf", 32'(ovf), 32'h0);

    // Single change on channel 2; enable low first must hold state
    evt_if.evt_ready = 1'b1;
    nst = 16'h0500;
    #1;
    check_eq("single.xst", 32'(xst), 32'h4);
    step();
    check_eq("single.hold_cst", 32'(cst), 32'h0);
    check_eq("single.hold_valid", 32'(evt_if.evt_valid), 32'h0);
    en = 4'b0100;
    step();
    en = '0;
    check_eq("single.cst", 32'(cst), 32'h0500);
    check_eq("single.latency", 32'(evt_if.evt_valid), 32'h0);
    step();
    check_evt("single.evt", 1'b1, 2'd2, 4'h0, 4'h5);
    step();
    check_eq("single.drain", 32'(evt_if.evt_valid), 32'h0);

    // Simultaneous changes, drained in channel order from a fresh pointer
    do_reset();
    nst = 16'h4321;
    en = 4'hF;
    step();
    en = '0;
    check_eq("simul.cst", 32'(cst), 32'h4321);
    step(); check_evt("simul.e0", 1'b1, 2'd0, 4'h0, 4'h1);
    step(); check_evt("simul.e1", 1'b1, 2'd1, 4'h0, 4'h2);
    step(); check_evt("simul.e2", 1'b1, 2'd2, 4'h0, 4'h3);
    step(); check_evt("simul.e3", 1'b1, 2'd3, 4'h0, 4'h4);
    step(); check_eq("simul.drain", 32'(evt_if.evt_valid), 32'h0);

    // Overflow: slot held by ch0, ch1 changes 0->3->7 and coalesces
    do_reset();
    evt_if.evt_ready = 1'b0;
    nst = 16'h0001; en = 4'b0001; step();
    en = '0; step();
    check_evt("ovf.blocker", 1'b1, 2'd0, 4'h0, 4'h1);
    nst = 16'h0031; en = 4'b0010; step();
    check_eq("ovf.first_no_ovf", 32'(ovf), 32'h0);
    nst = 16'h0071; en = 4'b0010; step();
    en = '0;
    check_eq("ovf.set", 32'(ovf), 32'h2);
    check_evt("ovf.stable", 1'b1, 2'd0, 4'h0, 4'h1);

    // Pop collision: ch1 record loads into the slot while ch1 goes 7->9
    evt_if.evt_ready = 1'b1;
    nst = 16'h0091; en = 4'b0010; step();
    en = '0;
    check_evt("ovf.coalesced", 1'b1, 2'd1, 4'h0, 4'h7);
    check_eq("pop.cst", 32'(cst), 32'h0091);
    check_eq("pop.ovf_kept", 32'(ovf), 32'h2);
    step();
    check_evt("pop.fresh", 1'b1, 2'd1, 4'h7, 4'h9);
    check_eq("pop.ovf_unchanged", 32'(ovf), 32'h2);
    step();
    check_eq("pop.drain", 32'(evt_if.evt_valid), 32'h0);

    // Preset with a record in the slot and another pending
    evt_if.evt_ready = 1'b0;
    nst = 16'h0092; en = 4'b0001; step();
    en = '0; step();
    check_evt("pre.slot", 1'b1, 2'd0, 4'h1, 4'h2);
    nst = 16'h0392; en = 4'b0100; step();
    en = '0;
    setn = 1'b0;
    nst = 16'hAAAA;
    step();
    setn = 1'b1;
    check_eq("pre.cst", 32'(cst), 32'hAAAA);
    check_eq("pre.valid", 32'(evt_if.evt_valid), 32'h0);
    check_eq("pre.ovf_kept", 32'(ovf), 32'h2);
    check_eq("pre.xst", 32'(xst), 32'h0);
    step();
    check_eq("pre.pending_cleared", 32'(evt_if.evt_valid), 32'h0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check_eq("pre.ovf_clr", 32'(ovf), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
